hls_deadlock_multi_monitor: RTL and testbench

Parametrised deadlock monitor for HLS dataflow regions with several AXI-Stream channels and several sub-instances. It filters transient stalls with a programmable persistence threshold, reports a sticky or self-clearing `block` flag, and latches which sources caused the stall. It sits beside the top-level dataflow instance and feeds the debug/status register path, where the single-channel, single-cycle monitor used to sit.

---
 rtl/hls_deadlock_multi_monitor.sv | 125 ++++++++++++
 tb/tb_hls_deadlock_multi_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor for an HLS dataflow region with several AXI-Stream
// channels and several sub-instances. A stall must persist for THRESHOLD
// consecutive cycles before it is declared. The sources involved are latched
// on entry to BLOCKED. With STICKY=1 the flag holds until clear.
module hls_deadlock_multi_monitor #(
   parameter int N_AXIS    = 4,
   parameter int N_INST    = 2,
   parameter int CNT_W     = 16,
   parameter int THRESHOLD = 1024,
   parameter int STICKY    = 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [N_AXIS-1:0]        axis_block_sigs,
   input  logic [N_INST-1:0]        inst_idle_sigs,
   input  logic [N_INST-1:0]        inst_block_sigs,
   output logic                     block,
   output logic                     block_pulse,
   output logic [N_AXIS+N_INST-1:0] block_src,
   output logic [CNT_W-1:0]         stall_count
);

   localparam int SRC_W = N_AXIS + N_INST;
   localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

   typedef enum logic [1:0] {IDLE, WATCH, BLOCKED} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             block_nxt;
   logic             pulse_nxt;
   logic [SRC_W-1:0] src_nxt;
   logic [SRC_W-1:0] src;
   logic             cand;

   // An idle instance never counts as blocked, even if it reports blocked.
   assign src  = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
   assign cand = |src;

   // Next-state, counter and capture logic. Clear overrides every transition.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_nxt = state;
      count_nxt = stall_count;
      block_nxt = block;
      pulse_nxt = 1'b0;
      src_nxt   = block_src;
      if (clear) begin
         state_nxt = IDLE;
         count_nxt = '0;
         block_nxt = 1'b0;
         src_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               count_nxt = '0;
               if (enable && cand) begin
                  count_nxt = CNT_W'(1);
                  if (THRESHOLD == 1) begin
                     // Threshold of one keeps the legacy single-cycle behaviour.
                     state_nxt = BLOCKED;
                     block_nxt = 1'b1;
                     pulse_nxt = 1'b1;
                     src_nxt   = src;
                  end else begin
                     state_nxt = WATCH;
                  end
               end
            end
            WATCH: begin
               if (!cand || !enable) begin
                  state_nxt = IDLE;
                  count_nxt = '0;
               end else begin
                  // The count is always below THR here, so this cannot wrap.
                  count_nxt = stall_count + CNT_W'(1);
                  if (count_nxt == THR) begin
                     state_nxt = BLOCKED;
                     block_nxt = 1'b1;
                     pulse_nxt = 1'b1;
                     src_nxt   = src;
                  end
               end
            end
            BLOCKED: begin
               if (STICKY == 0 && !cand) begin
                  state_nxt = IDLE;
                  count_nxt = '0;
                  block_nxt = 1'b0;
                  src_nxt   = '0;
               end else begin
                  count_nxt = THR;
               end
            end
            default: begin
               state_nxt = IDLE;
               count_nxt = '0;
               block_nxt = 1'b0;
               src_nxt   = '0;
            end
         endcase
      end
   end

   // State and registered outputs. All of them return to zero or IDLE on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         stall_count <= '0;
         block       <= 1'b0;
         block_pulse <= 1'b0;
         block_src   <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, so their order here does not matter.
         state       <= state_nxt;
         stall_count <= count_nxt;
         block       <= block_nxt;
         block_pulse <= pulse_nxt;
         block_src   <= src_nxt;
      end
   end

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Directed bench for hls_deadlock_multi_monitor. Four instances share the
// stimulus: threshold 4 sticky, threshold 4 non-sticky, threshold 1024 and
// threshold 1. Each scenario checks the instance it is aimed at.
module tb_hls_deadlock_multi_monitor;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] axis_block_sigs = '0;
   logic [1:0] inst_idle_sigs = '0;
   logic [1:0] inst_block_sigs = '0;

   logic        blk_s, pls_s, blk_n, pls_n, blk_b, pls_b, blk_1, pls_1;
   logic [5:0]  src_s, src_n, src_b, src_1;
   logic [15:0] cnt_s, cnt_n, cnt_b, cnt_1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   hls_deadlock_multi_monitor #(.THRESHOLD(4), .STICKY(1)) u_s (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .block(blk_s), .block_pulse(pls_s),
      .block_src(src_s), .stall_count(cnt_s));

   hls_deadlock_multi_monitor #(.THRESHOLD(4), .STICKY(0)) u_n (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .block(blk_n), .block_pulse(pls_n),
      .block_src(src_n), .stall_count(cnt_n));

   hls_deadlock_multi_monitor #(.THRESHOLD(1024), .STICKY(1)) u_b (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .block(blk_b), .block_pulse(pls_b),
      .block_src(src_b), .stall_count(cnt_b));

   hls_deadlock_multi_monitor #(.THRESHOLD(1), .STICKY(1)) u_1 (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .block(blk_1), .block_pulse(pls_1),
      .block_src(src_1), .stall_count(cnt_1));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One rising edge, then settle 1 ns so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      enable          = 1'b0;
      clear           = 1'b0;
      axis_block_sigs = '0;
      inst_idle_sigs  = '0;
      inst_block_sigs = '0;
      #12;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      logic pat [8]     = '{1, 1, 1, 0, 1, 1, 1, 1};
      int   exp_cnt [8] = '{1, 2, 3, 0, 1, 2, 3, 4};

      // Reset state
      do_reset();
      check("rst_block", 32'(blk_s), 0);
      check("rst_pulse", 32'(pls_s), 0);
      check("rst_src",   32'(src_s), 0);
      check("rst_count", 32'(cnt_s), 0);

      // Constant stall on axis channel 1
      enable = 1'b1;
      axis_block_sigs = 4'b0010;
      step();
      check("t1_block", 32'(blk_1), 1);
      check("t1_pulse", 32'(pls_1), 1);
      check("t1_src",   32'(src_1), 32'h02);
      check("e1_count", 32'(cnt_s), 1);
      check("e1_block", 32'(blk_s), 0);
      step();
      check("e2_count", 32'(cnt_s), 2);
      check("t1_pulse_low", 32'(pls_1), 0);
      check("t1_block_held", 32'(blk_1), 1);
      step();
      check("e3_count", 32'(cnt_s), 3);
      check("e3_block", 32'(blk_s), 0);
      step();
      check("e4_block", 32'(blk_s), 1);
      check("e4_pulse", 32'(pls_s), 1);
      check("e4_src",   32'(src_s), 32'h02);
      check("e4_count", 32'(cnt_s), 4);
      check("e4_block_ns", 32'(blk_n), 1);
      step();
      check("e5_pulse", 32'(pls_s), 0);
      check("e5_block", 32'(blk_s), 1);
      check("e5_count_sat", 32'(cnt_s), 4);

      // Stall ends: non-sticky releases, sticky holds
      axis_block_sigs = '0;
      step();
      check("ns_release_block", 32'(blk_n), 0);
      check("ns_release_src",   32'(src_n), 0);
      check("ns_release_count", 32'(cnt_n), 0);
      check("st_hold_block",    32'(blk_s), 1);
      repeat (99) step();
      check("st_hold100_block", 32'(blk_s), 1);
      check("st_hold100_src",   32'(src_s), 32'h02);
      check("st_hold100_count", 32'(cnt_s), 4);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_block", 32'(blk_s), 0);
      check("clr_pulse", 32'(pls_s), 0);
      check("clr_src",   32'(src_s), 0);
      check("clr_count", 32'(cnt_s), 0);

      // Single gap in the stall restarts the count
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         axis_block_sigs = pat[i] ? 4'b0001 : 4'b0000;
         step();
         check($sformatf("gap_count_%0d", i + 1), 32'(cnt_s), 32'(exp_cnt[i]));
         check($sformatf("gap_block_%0d", i + 1), 32'(blk_s), (i == 7) ? 1 : 0);
      end

      // Instance sources, with the idle mask applied
      do_reset();
      enable = 1'b1;
      inst_block_sigs = 2'b11;
      inst_idle_sigs  = 2'b01;
      repeat (4) step();
      check("inst_block", 32'(blk_s), 1);
      check("inst_src",   32'(src_s), 32'h20);
      do_reset();
      enable = 1'b1;
      inst_block_sigs = 2'b11;
      inst_idle_sigs  = 2'b11;
      repeat (3) step();
      check("idle_count", 32'(cnt_s), 0);
      check("idle_block", 32'(blk_s), 0);

      // Asynchronous reset in the middle of WATCH
      do_reset();
      enable = 1'b1;
      axis_block_sigs = 4'b0001;
      repeat (500) step();
      check("mid_count_500", 32'(cnt_b), 500);
      check("mid_s_block", 32'(blk_s), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_count", 32'(cnt_b), 0);
      check("async_s_block", 32'(blk_s), 0);
      check("async_s_src",   32'(src_s), 0);
      check("async_s_count", 32'(cnt_s), 0);
      @(negedge clock);
      reset_n = 1'b1;
      step();
      check("post_rst_count", 32'(cnt_b), 1);
      check("post_rst_block", 32'(blk_b), 0);

      // Enable low holds the monitor in IDLE
      do_reset();
      enable = 1'b0;
      axis_block_sigs = 4'b0001;
      for (int i = 0; i < 2000; i++) begin
         step();
         check("dis_count", 32'(cnt_b), 0);
         check("dis_block", 32'(blk_b), 0);
      end

      // Clear on the threshold edge wins
      enable = 1'b1;
      repeat (1023) step();
      check("pre_thr_count", 32'(cnt_b), 1023);
      check("pre_thr_block", 32'(blk_b), 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_thr_block", 32'(blk_b), 0);
      check("clr_thr_pulse", 32'(pls_b), 0);
      check("clr_thr_count", 32'(cnt_b), 0);
      step();
      check("after_clr_count", 32'(cnt_b), 1);
      check("after_clr_pulse", 32'(pls_b), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
